// File: rtl/test_status_sequencer_pkg.sv
// Shared definitions for the test-status sequencer: register map, bit positions, FSM states.
package test_status_sequencer_pkg;

   // Register index, taken from bus_addr[3:2]
   localparam logic [1:0] RegCtrl       = 2'd0;
   localparam logic [1:0] RegResult     = 2'd1;
   localparam logic [1:0] RegWdogReload = 2'd2;
   localparam logic [1:0] RegStatus     = 2'd3;

   // CTRL bits
   localparam int unsigned CtrlOutEnBit  = 0;
   localparam int unsigned CtrlWdogEnBit = 1;

   // STATUS bits
   localparam int unsigned StatusBusyBit    = 0;
   localparam int unsigned StatusPendingBit = 1;
   localparam int unsigned StatusStickyBit  = 2;
   localparam int unsigned StatusWdogBit    = 3;
   localparam int unsigned StatusClrCntBit  = 4;
   localparam int unsigned StatusPassLsb    = 8;
   localparam int unsigned StatusFailLsb    = 16;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StStrobe,
      StGap
   } seq_state_e;

   // 8-bit increment that sticks at 255
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/test_status_watchdog.sv
// Watchdog for the test-status sequencer: counts down from a reload value and requests a
// failure injection on expiry; stalls at zero until the pending slot grants the request.
module test_status_watchdog #(
   parameter int unsigned WDOG_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wdog_en,
   input  logic                  load,
   input  logic                  reload_we,
   input  logic [WDOG_WIDTH-1:0] reload_wdata,
   input  logic                  gnt,
   output logic                  req,
   output logic [WDOG_WIDTH-1:0] reload
);

   localparam logic [WDOG_WIDTH-1:0] CountOne = WDOG_WIDTH'(1);

   logic [WDOG_WIDTH-1:0] reload_q;
   logic [WDOG_WIDTH-1:0] count_q;
   logic                  active;

   // Expiry fires on the cycle the count would reach zero, or while stalled at zero
   always_comb begin
      active = wdog_en && (reload_q != '0);
      req    = active && ((count_q == CountOne) || (count_q == '0));
   end

   // Reload register and down-counter; an explicit load always beats expiry
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reload_q <= '0;
         count_q  <= '0;
      end else begin
         if (reload_we) begin
            reload_q <= reload_wdata;
         end
         if (load) begin
            count_q <= reload_we ? reload_wdata : reload_q;
         end else if (active) begin
            if (req) begin
               count_q <= gnt ? reload_q : '0;
            end else begin
               count_q <= count_q - CountOne;
            end
         end
      end
   end

   assign reload = reload_q;

endmodule

// File: rtl/test_status_sequencer.sv
// Memory-mapped sequencer for the success / next_test report pins with a one-deep result
// slot, pass/fail counters and a failure-injecting watchdog.
module test_status_sequencer
   import test_status_sequencer_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES  = 4,
   parameter int unsigned STROBE_CYCLES = 16,
   parameter int unsigned GAP_CYCLES    = 16,
   parameter int unsigned WDOG_WIDTH    = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bus_req,
   input  logic        bus_we,
   input  logic [3:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        bus_ack,
   output logic        success_o,
   output logic        next_test_o,
   output logic [1:0]  io_oeb
);

   localparam logic [15:0] SetupLast  = 16'(SETUP_CYCLES - 1);
   localparam logic [15:0] StrobeLast = 16'(STROBE_CYCLES - 1);
   localparam logic [15:0] GapLast    = 16'(GAP_CYCLES - 1);

   seq_state_e            state_q;
   logic [15:0]           cnt_q;
   logic [1:0]            ctrl_q;
   logic                  pending_q, pending_pass_q;
   logic                  sticky_fail_q, wdog_fired_q;
   logic [7:0]            pass_cnt_q, fail_cnt_q;
   logic                  success_q, next_test_q;
   logic                  bus_ack_q;
   logic [31:0]           bus_rdata_q;

   logic [1:0]            reg_idx;
   logic                  bus_sel, result_wr, bus_accept, result_enq;
   logic                  ctrl_wr, reload_wr, status_wr;
   logic                  wdog_load, wdog_req, wdog_gnt;
   logic [31:0]           status_val, rd_val;
   logic [WDOG_WIDTH-1:0] wdog_reload;
   logic                  unused_bits;

   // Bus decode; a RESULT write into a full slot is left unacknowledged and retried
   always_comb begin
      reg_idx    = bus_addr[3:2];
      bus_sel    = bus_req && !bus_ack_q;
      result_wr  = bus_sel && bus_we && (reg_idx == RegResult);
      bus_accept = bus_sel && !(result_wr && pending_q);
      result_enq = result_wr && !pending_q;
      ctrl_wr    = bus_accept && bus_we && (reg_idx == RegCtrl);
      reload_wr  = bus_accept && bus_we && (reg_idx == RegWdogReload);
      status_wr  = bus_accept && bus_we && (reg_idx == RegStatus);
      wdog_load  = result_enq || reload_wr ||
                   (ctrl_wr && bus_wdata[CtrlWdogEnBit] && !ctrl_q[CtrlWdogEnBit]);
      wdog_gnt   = wdog_req && !pending_q && !wdog_load;

      status_val                                = '0;
      status_val[StatusBusyBit]                 = (state_q != StIdle);
      status_val[StatusPendingBit]              = pending_q;
      status_val[StatusStickyBit]               = sticky_fail_q;
      status_val[StatusWdogBit]                 = wdog_fired_q;
      status_val[StatusPassLsb+:8]              = pass_cnt_q;
      status_val[StatusFailLsb+:8]              = fail_cnt_q;

      rd_val = '0;
      case (reg_idx)
         RegCtrl:       rd_val = {30'd0, ctrl_q};
         RegWdogReload: rd_val = 32'(wdog_reload);
         RegStatus:     rd_val = status_val;
         default:       rd_val = '0;
      endcase
   end

   assign unused_bits = ^{bus_addr[1:0], bus_wdata};

   test_status_watchdog #(
      .WDOG_WIDTH (WDOG_WIDTH)
   ) u_watchdog (
      .clk          (clk),
      .rst_n        (rst_n),
      .wdog_en      (ctrl_q[CtrlWdogEnBit]),
      .load         (wdog_load),
      .reload_we    (reload_wr),
      .reload_wdata (bus_wdata[WDOG_WIDTH-1:0]),
      .gnt          (wdog_gnt),
      .req          (wdog_req),
      .reload       (wdog_reload)
   );

   // Bus acknowledge, read data and CTRL register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus_ack_q   <= 1'b0;
         bus_rdata_q <= '0;
         ctrl_q      <= '0;
      end else begin
         bus_ack_q   <= bus_accept;
         bus_rdata_q <= (bus_accept && !bus_we) ? rd_val : '0;
         if (ctrl_wr) begin
            ctrl_q <= bus_wdata[1:0];
         end
      end
   end

   // Pending slot, pin FSM, counters and sticky flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         pending_q      <= 1'b0;
         pending_pass_q <= 1'b0;
         sticky_fail_q  <= 1'b0;
         wdog_fired_q   <= 1'b0;
         pass_cnt_q     <= '0;
         fail_cnt_q     <= '0;
         success_q      <= 1'b0;
         next_test_q    <= 1'b0;
      end else begin
         // Enqueue only into an empty slot, dequeue only from a full one: never both at once
         if (result_enq) begin
            pending_q      <= 1'b1;
            pending_pass_q <= bus_wdata[0];
         end else if (wdog_gnt) begin
            pending_q      <= 1'b1;
            pending_pass_q <= 1'b0;
            wdog_fired_q   <= 1'b1;
         end

         case (state_q)
            StIdle: begin
               if (pending_q) begin
                  pending_q <= 1'b0;
                  success_q <= pending_pass_q;
                  cnt_q     <= '0;
                  state_q   <= StSetup;
               end
            end
            StSetup: begin
               if (cnt_q == SetupLast) begin
                  cnt_q       <= '0;
                  next_test_q <= 1'b1;
                  state_q     <= StStrobe;
                  if (success_q) begin
                     pass_cnt_q <= sat_inc(pass_cnt_q);
                  end else begin
                     fail_cnt_q    <= sat_inc(fail_cnt_q);
                     sticky_fail_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            StStrobe: begin
               if (cnt_q == StrobeLast) begin
                  cnt_q       <= '0;
                  next_test_q <= 1'b0;
                  state_q     <= StGap;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            StGap: begin
               if (cnt_q == GapLast) begin
                  cnt_q   <= '0;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: state_q <= StIdle;
         endcase

         // Firmware clears are applied last so they win over a same-cycle update
         if (status_wr) begin
            if (bus_wdata[StatusStickyBit]) sticky_fail_q <= 1'b0;
            if (bus_wdata[StatusWdogBit])   wdog_fired_q  <= 1'b0;
            if (bus_wdata[StatusClrCntBit]) begin
               pass_cnt_q <= '0;
               fail_cnt_q <= '0;
            end
         end
      end
   end

   assign bus_ack     = bus_ack_q;
   assign bus_rdata   = bus_rdata_q;
   assign success_o   = success_q;
   assign next_test_o = next_test_q;
   assign io_oeb      = ctrl_q[CtrlOutEnBit] ? 2'b00 : 2'b11;

endmodule

// File: tb/tb_test_status_sequencer.sv
// Self-checking bench for test_status_sequencer: bus reads and report strobes are checked
// against expectations queued when the stimulus is issued.
module tb_test_status_sequencer;

   localparam logic [3:0] ACtrl   = 4'h0;
   localparam logic [3:0] AResult = 4'h4;
   localparam logic [3:0] AReload = 4'h8;
   localparam logic [3:0] AStatus = 4'hC;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bus_req;
   logic        bus_we;
   logic [3:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        success_o;
   logic        next_test_o;
   logic [1:0]  io_oeb;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] rd_q[$];
   logic        strobe_q[$];
   logic        nt_prev = 1'b0;
   logic        exp_level = 1'b0;

   test_status_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus_req     (bus_req),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_rdata   (bus_rdata),
      .bus_ack     (bus_ack),
      .success_o   (success_o),
      .next_test_o (next_test_o),
      .io_oeb      (io_oeb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // One bus access; called just after a rising edge, returns just after the ack edge
   task automatic xfer(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int waited);
      bus_req   = 1'b1;
      bus_we    = we;
      bus_addr  = addr;
      bus_wdata = wdata;
      waited    = 0;
      do begin
         @(posedge clk);
         #1;
         waited++;
      end while (!bus_ack && waited < 200);
      check("bus_ack", 32'(bus_ack), 32'd1);
      rdata   = bus_rdata;
      bus_req = 1'b0;
      bus_we  = 1'b0;
   endtask

   task automatic wr(input logic [3:0] addr, input logic [31:0] data);
      logic [31:0] r;
      int          w;
      xfer(1'b1, addr, data, r, w);
   endtask

   task automatic rd_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
      logic [31:0] r;
      int          w;
      rd_q.push_back(exp);
      xfer(1'b0, addr, 32'd0, r, w);
      check(tag, r, rd_q.pop_front());
   endtask

   task automatic wait_idle();
      logic [31:0] r;
      int          w;
      int          polls = 0;
      do begin
         xfer(1'b0, AStatus, 32'd0, r, w);
         polls++;
      end while ((r[1:0] != 2'b00) && polls < 300);
      check("idle_reached", 32'(r[1:0]), 32'd0);
   endtask

   // Strobe scoreboard: level at each rising next_test_o and held for the whole strobe
   always @(negedge clk) begin
      if (next_test_o && !nt_prev) begin
         if (strobe_q.size() == 0) begin
            check("strobe_expected", 32'(strobe_q.size()), 32'd1);
         end else begin
            exp_level = strobe_q.pop_front();
            check("strobe_pass", 32'(success_o), 32'(exp_level));
         end
      end else if (next_test_o) begin
         check("success_stable", 32'(success_o), 32'(exp_level));
      end
      nt_prev = next_test_o;
   end

   initial begin
      #600000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int k;
      int w1, w2, w3;
      logic [31:0] r;

      bus_req   = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = '0;
      bus_wdata = '0;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_success", 32'(success_o), 32'd0);
      check("rst_next_test", 32'(next_test_o), 32'd0);
      check("rst_oeb", 32'(io_oeb), 32'd3);
      check("rst_ack", 32'(bus_ack), 32'd0);
      check("rst_rdata", bus_rdata, 32'd0);
      rst_n = 1'b1;
      rd_check("rst_status", AStatus, 32'h0);
      wr(ACtrl, 32'h1);
      check("oeb_enabled", 32'(io_oeb), 32'd0);
      rd_check("ctrl_rb", ACtrl, 32'h1);
      rd_check("result_reads_zero", AResult, 32'h0);

      // Single pass report with exact phase lengths
      strobe_q.push_back(1'b1);
      wr(AResult, 32'h1);
      @(posedge clk);
      #1;
      check("t1_success", 32'(success_o), 32'd1);
      check("t1_nt_low", 32'(next_test_o), 32'd0);
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!next_test_o && k < 50);
      check("t1_setup_len", 32'(k), 32'd4);
      k = 0;
      while (next_test_o && k < 50) begin
         k++;
         @(posedge clk);
         #1;
      end
      check("t1_strobe_len", 32'(k), 32'd16);
      repeat (14) @(posedge clk);
      #1;
      check("t1_gap_low", 32'(next_test_o), 32'd0);
      rd_check("t1_status_gap_end", AStatus, 32'h0000_0101);
      rd_check("t1_status_idle", AStatus, 32'h0000_0100);

      // Back-to-back reports 1,0,1
      wr(AStatus, 32'h1C);
      strobe_q.push_back(1'b1);
      strobe_q.push_back(1'b0);
      strobe_q.push_back(1'b1);
      xfer(1'b1, AResult, 32'h1, r, w1);
      xfer(1'b1, AResult, 32'h0, r, w2);
      xfer(1'b1, AResult, 32'h1, r, w3);
      check("t2_wr2_quick", 32'(w2 <= 2), 32'd1);
      check("t2_wr3_delayed", 32'(w3 >= 30), 32'd1);
      wait_idle();
      rd_check("t2_status", AStatus, 32'h0001_0204);

      // Watchdog expiry injects a fail
      wr(AStatus, 32'h1C);
      wr(AReload, 32'd100);
      rd_check("reload_rb", AReload, 32'd100);
      strobe_q.push_back(1'b0);
      wr(ACtrl, 32'h3);
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!next_test_o && k < 200);
      check("t3_wdog_strobe_at", 32'(k), 32'd105);
      wr(ACtrl, 32'h1);
      wait_idle();
      rd_check("t3_status", AStatus, 32'h0001_000C);

      // RESULT write on the expiry cycle wins; no injection
      wr(AStatus, 32'h1C);
      wr(ACtrl, 32'h3);
      repeat (99) @(posedge clk);
      #1;
      strobe_q.push_back(1'b1);
      wr(AResult, 32'h1);
      wr(ACtrl, 32'h1);
      wait_idle();
      rd_check("t4_status", AStatus, 32'h0000_0100);

      // Reset in the middle of a strobe
      strobe_q.push_back(1'b1);
      wr(AResult, 32'h1);
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!next_test_o && k < 20);
      check("t5_strobe_seen", 32'(next_test_o), 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("t5_nt_dropped", 32'(next_test_o), 32'd0);
      check("t5_success_rst", 32'(success_o), 32'd0);
      check("t5_oeb", 32'(io_oeb), 32'd3);
      rst_n = 1'b1;
      rd_check("t5_status", AStatus, 32'h0);
      rd_check("t5_ctrl", ACtrl, 32'h0);
      rd_check("t5_reload", AReload, 32'h0);

      // Fail count saturation and clears
      for (int i = 0; i < 256; i++) begin
         strobe_q.push_back(1'b0);
         wr(AResult, 32'h0);
      end
      wait_idle();
      rd_check("t6_saturated", AStatus, 32'h00FF_0004);
      wr(AStatus, 32'h10);
      rd_check("t6_counts_cleared", AStatus, 32'h0000_0004);
      wr(AStatus, 32'h04);
      rd_check("t6_sticky_cleared", AStatus, 32'h0);

      check("sb_drained", 32'(strobe_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
